// File: rtl/out_bcd_display.sv
// Output-port display reader: free-running double-dabble conversion of a 32-bit register value
// into active-low seven-segment patterns, republished every 34 cycles.
module out_bcd_display #(
  parameter int unsigned DIGITS = 8,
  parameter bit          SIGNED = 1'b0,
  parameter bit          BLANK  = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           value,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  valid,
  output logic                  frame,
  output logic                  overflow,
  output logic                  negative
);

  typedef enum logic [1:0] {
    StCapture,
    StShift,
    StPublish
  } state_t;

  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] SegMinus = 7'b0111111;

  state_t stateQ, stateD;

  logic [31:0]         binQ;
  logic [39:0]         bcdQ;
  logic [4:0]          cntQ;
  logic                negQ;
  logic [7*DIGITS-1:0] segQ;
  logic                validQ;
  logic                frameQ;
  logic                ovfQ;
  logic                negOutQ;

  logic [31:0]         magnitude;
  logic [38:0]         bcdAdj;
  logic [39:0]         bcdNext;
  logic [31:0]         binNext;
  logic [7*DIGITS-1:0] segNext;
  logic                ovfNext;

  function automatic logic [6:0] encodeDigit(input logic [3:0] d);
    logic [6:0] pat;
    pat = SegBlank;
    case (d)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = SegBlank;
    endcase
    return pat;
  endfunction

  // Two's-complement magnitude; -2^31 naturally yields 2147483648 as unsigned.
  always_comb begin
    magnitude = value;
    if (SIGNED && value[31]) begin
      magnitude = 32'(~value + 32'd1);
    end
  end

  // Nibble 9 never reaches 5 before the final shift (2^32 < 5e9), so only its low bits move up.
  always_comb begin
    bcdAdj = '0;
    for (int k = 0; k < 9; k++) begin
      if (bcdQ[4*k +: 4] >= 4'd5) begin
        bcdAdj[4*k +: 4] = bcdQ[4*k +: 4] + 4'd3;
      end else begin
        bcdAdj[4*k +: 4] = bcdQ[4*k +: 4];
      end
    end
    bcdAdj[38:36] = bcdQ[38:36];
    bcdNext = {bcdAdj, binQ[31]};
    binNext = {binQ[30:0], 1'b0};
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StCapture: stateD = StShift;
      StShift:   stateD = (cntQ == 5'd31) ? StPublish : StShift;
      StPublish: stateD = StCapture;
      default:   stateD = StCapture;
    endcase
  end

  // Publish-side decode: leading-zero blanking, minus placement and overflow detection.
  always_comb begin
    int unsigned msd;
    msd     = 0;
    ovfNext = 1'b0;
    segNext = '1;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (bcdQ[4*k +: 4] != 4'd0) begin
        msd = k;
      end
    end
    for (int k = int'(DIGITS); k < 10; k++) begin
      if (bcdQ[4*k +: 4] != 4'd0) begin
        ovfNext = 1'b1;
      end
    end
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (BLANK && (k > int'(msd))) begin
        segNext[7*k +: 7] = (negQ && (k == int'(msd) + 1)) ? SegMinus : SegBlank;
      end else begin
        segNext[7*k +: 7] = encodeDigit(bcdQ[4*k +: 4]);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      stateQ  <= StCapture;
      cntQ    <= '0;
      binQ    <= '0;
      bcdQ    <= '0;
      negQ    <= 1'b0;
      segQ    <= '1;
      validQ  <= 1'b0;
      frameQ  <= 1'b0;
      ovfQ    <= 1'b0;
      negOutQ <= 1'b0;
    end else begin
      stateQ <= stateD;
      frameQ <= 1'b0;
      unique case (stateQ)
        StCapture: begin
          binQ <= magnitude;
          negQ <= SIGNED && value[31];
          bcdQ <= '0;
          cntQ <= '0;
        end
        StShift: begin
          binQ <= binNext;
          bcdQ <= bcdNext;
          cntQ <= cntQ + 5'd1;
        end
        StPublish: begin
          segQ    <= segNext;
          ovfQ    <= ovfNext;
          negOutQ <= negQ;
          validQ  <= 1'b1;
          frameQ  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign seg      = segQ;
  assign valid    = validQ;
  assign frame    = frameQ;
  assign overflow = ovfQ;
  assign negative = SIGNED ? negOutQ : 1'b0;

endmodule

// File: tb/tb_out_bcd_display.sv
// Directed bench for out_bcd_display: three parameterisations share clock, reset and value.
module tb_out_bcd_display;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] value = 32'd0;

  logic [55:0] segA, segB, segC;
  logic        validA, validB, validC;
  logic        frameA, frameB, frameC;
  logic        ovfA, ovfB, ovfC;
  logic        negA, negB, negC;

  int nCompared   = 0;
  int nMismatched = 0;
  int n;

  always #5 clock = ~clock;

  out_bcd_display #(.DIGITS(8), .SIGNED(1'b0), .BLANK(1'b1)) dutA (
    .clock(clock), .reset(reset), .value(value), .seg(segA), .valid(validA),
    .frame(frameA), .overflow(ovfA), .negative(negA)
  );

  out_bcd_display #(.DIGITS(8), .SIGNED(1'b0), .BLANK(1'b0)) dutB (
    .clock(clock), .reset(reset), .value(value), .seg(segB), .valid(validB),
    .frame(frameB), .overflow(ovfB), .negative(negB)
  );

  out_bcd_display #(.DIGITS(8), .SIGNED(1'b1), .BLANK(1'b1)) dutC (
    .clock(clock), .reset(reset), .value(value), .seg(segC), .valid(validC),
    .frame(frameC), .overflow(ovfC), .negative(negC)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Nibble codes per digit (digit7..digit0): 0-9 digits, A blank, B minus.
  function automatic logic [55:0] expSeg(input logic [31:0] codes);
    logic [55:0] s;
    logic [6:0]  p;
    s = '1;
    for (int k = 0; k < 8; k++) begin
      case (codes[4*k +: 4])
        4'h0:    p = 7'b1000000;
        4'h1:    p = 7'b1111001;
        4'h2:    p = 7'b0100100;
        4'h3:    p = 7'b0110000;
        4'h4:    p = 7'b0011001;
        4'h5:    p = 7'b0010010;
        4'h6:    p = 7'b0000010;
        4'h7:    p = 7'b1111000;
        4'h8:    p = 7'b0000000;
        4'h9:    p = 7'b0010000;
        4'hB:    p = 7'b0111111;
        default: p = 7'b1111111;
      endcase
      s[7*k +: 7] = p;
    end
    return s;
  endfunction

  task automatic waitFrame(output int cycles);
    cycles = 0;
    while (cycles < 40) begin
      @(posedge clock);
      #1;
      cycles++;
      if (frameA) break;
    end
    if (!frameA) check("frameTimeout", {63'd0, frameA}, 64'd1);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("rstSeg", segA, {56{1'b1}});
    check("rstValid", validA, 0);
    check("rstFrame", frameA, 0);
    check("rstOvf", ovfA, 0);
    check("rstNegC", negC, 0);

    reset = 1'b1;
    waitFrame(n);
    check("firstLatency", n, 34);
    check("zeroSeg", segA, expSeg(32'hAAAAAAA0));
    check("zeroValid", validA, 1);
    check("zeroOvf", ovfA, 0);

    value = 32'd12345678;
    @(posedge clock);
    #1;
    check("frameOnce", frameA, 0);
    waitFrame(n);
    check("period", n, 33);
    check("dec8Seg", segA, expSeg(32'h12345678));
    check("dec8Ovf", ovfA, 0);
    check("dec8Neg", negA, 0);

    value = 32'hFFFFFFFF;
    waitFrame(n);
    check("maxSegA", segA, expSeg(32'h94967295));
    check("maxOvfA", ovfA, 1);
    check("maxNegA", negA, 0);
    check("maxSegB", segB, expSeg(32'h94967295));
    check("minus1SegC", segC, expSeg(32'hAAAAAAB1));
    check("minus1NegC", negC, 1);
    check("minus1OvfC", ovfC, 0);

    value = 32'd42;
    waitFrame(n);
    check("noBlankSegB", segB, expSeg(32'h00000042));
    check("blankSegA", segA, expSeg(32'hAAAAAA42));
    check("posNegC", negC, 0);

    value = 32'hFFFFFF85;
    waitFrame(n);
    check("m123SegC", segC, expSeg(32'hAAAAB123));
    check("m123NegC", negC, 1);
    check("m123OvfC", ovfC, 0);
    check("u173SegA", segA, expSeg(32'h94967173));
    check("u173OvfA", ovfA, 1);

    value = 32'h80000000;
    waitFrame(n);
    check("minIntSegC", segC, expSeg(32'h47483648));
    check("minIntOvfC", ovfC, 1);
    check("minIntNegC", negC, 1);
    check("minIntSegA", segA, expSeg(32'h47483648));

    value = 32'd5;
    repeat (11) @(posedge clock);
    #1;
    value = 32'd7;
    waitFrame(n);
    check("lateChangeOld", segA, expSeg(32'hAAAAAAA5));
    waitFrame(n);
    check("lateChangeNew", segA, expSeg(32'hAAAAAAA7));

    repeat (15) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("midRstSeg", segA, {56{1'b1}});
    check("midRstValid", validA, 0);
    check("midRstFrame", frameA, 0);
    @(posedge clock);
    #1;
    value = 32'd99;
    reset = 1'b1;
    waitFrame(n);
    check("rerunLatency", n, 34);
    check("rerunSeg", segA, expSeg(32'hAAAAAA99));
    check("rerunValid", validA, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
